mmio_timer: RTL
===============

MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 9'h180, 9-bit word address of register 0 (the block decodes BASE_ADDR..BASE_ADDR+2).
REQ-002 SHALL have parameter PRESCALE, default 16'd50000, clock cycles per count tick (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_cmd  input  2  bus command: 2'b00 none, 2'b01 read, 2'b10 write.
REQ-006 SHALL have port mem_addr  input  9  bus word address from cpu.
REQ-007 SHALL have port write_data  input  16  bus write data.
REQ-008 SHALL have port read_data  output  16  register read value, combinational.
REQ-009 SHALL have port rd_hit  output  1  high when mem_cmd is read and mem_addr is in BASE_ADDR..BASE_ADDR+2; top uses it to select read_data.
REQ-010 SHALL have port expired  output  1  sticky timeout flag, registered.

Function
REQ-011 Registers: offset 0 LOAD (R/W, 16b); offset 1 COUNT (R only, writes ignored); offset 2 CTRL (W) / STATUS (R).
REQ-012 CTRL write bits: bit0 start, bit1 stop, bit2 clear expired; other bits ignored; several bits may be set in one write.
REQ-013 STATUS read = {13'b0, autoreload_compiled, expired, running}.
REQ-014 A register write takes effect at the posedge where mem_cmd is write and the address hits; it is visible on read_data the next cycle.
REQ-015 read_data SHALL equal the addressed register while rd_hit is high, else 16'h0000.
REQ-016 FSM states: IDLE, RUN, DONE; running = (state == RUN).
REQ-017 start (any state): COUNT <= LOAD, prescaler <= 0, state <= RUN; if LOAD == 0, state <= DONE and expired <= 1 at that same edge instead.
REQ-018 stop: state <= IDLE, COUNT holds its value.
REQ-019 In RUN, the prescaler counts 0..PRESCALE-1 and then wraps; on the wrap cycle (tick), COUNT decrements by 1.
REQ-020 On a tick with COUNT == 1: COUNT <= 0, expired <= 1, state <= DONE (or reload per REQ-030).
REQ-021 DONE holds COUNT = 0 until start or stop; stop in DONE -> IDLE.
REQ-022 Priority at one edge: stop > start > tick; start+stop together -> IDLE with COUNT unchanged.
REQ-023 clear expired and an expiring tick at the same edge: expired stays 1 (set wins).
REQ-024 A LOAD write during RUN does not alter COUNT until the next start or reload.
REQ-025 COUNT arithmetic is unsigned 16-bit and never wraps below 0.

Reset
REQ-026 Reset low asynchronously forces state IDLE, LOAD = 0, COUNT = 0, prescaler = 0, expired = 0.
REQ-027 Reset asserted mid-RUN aborts the count; after release the block stays IDLE until a start.
REQ-028 read_data and rd_hit are combinational and follow REQ-015 during reset.

Configuration
REQ-029 Macro MMIO_TIMER_AUTORELOAD_EN selects reload behaviour.
REQ-030 With the macro defined, an expiring tick sets expired, loads COUNT <= LOAD, and stays in RUN (LOAD == 0 -> DONE); STATUS bit2 reads 1.
REQ-031 Without the macro, REQ-020 applies unchanged and STATUS bit2 reads 0.

Structure
REQ-032 Package mmio_pkg SHALL hold the MNONE/MREAD/MWRITE constants, the timer state enum, and the register offset constants.
REQ-033 The prescaler SHALL be a sub-module tick_gen (clk, reset, enable, clear, tick), parameterised by PRESCALE.

Verification (bench PRESCALE = 2)
REQ-034 Reset, then read BASE+2 -> read_data 16'h0000, rd_hit 1, expired 0.
REQ-035 Write LOAD = 3, write CTRL = 1 -> COUNT reads 3,2,1,0 at 2-cycle spacing; expired rises when COUNT reaches 0; STATUS reads 16'h0002.
REQ-036 Write LOAD = 0, then start -> expired = 1 and state DONE one cycle later, with no ticks.
REQ-037 Start with LOAD = 5, stop after 4 cycles -> COUNT holds 3 and STATUS = 0; write CTRL = 3'b011 -> IDLE, COUNT stays 3.
REQ-038 Drive reset low mid-count with LOAD = 8 -> COUNT = 0 and expired = 0 immediately (no clock edge); after release it stays IDLE.
REQ-039 With MMIO_TIMER_AUTORELOAD_EN defined, LOAD = 2, start -> COUNT sequence 2,1,2,1 repeats and running stays 1; clear expired written on an expiring tick leaves expired = 1.

Source files
------------

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared constants and types for the mmio_timer block
// Purpose: bus command encodings, timer state enum, register offsets, CTRL bit positions.
// Ports: none (package).
package mmio_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_e;

  localparam logic [1:0] OFF_LOAD  = 2'd0;
  localparam logic [1:0] OFF_COUNT = 2'd1;
  localparam logic [1:0] OFF_CTRL  = 2'd2;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_CLEAR = 2;

endpackage

// File: rtl/mmio_timer_tick_gen.sv
// rtl/mmio_timer_tick_gen.sv - prescaler producing one tick every PRESCALE enabled cycles
// Purpose: counts 0..PRESCALE-1 while enabled; tick is high in the wrap cycle.
// Ports: clk, reset (async active-low), enable (count), clear (sync restart at 0), tick (comb).
module tick_gen #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'd0;
    end else if (clear) begin
      cnt_q <= 16'd0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? 16'd0 : cnt_q + 16'd1;
    end
  end

  // A restart in the same cycle suppresses the tick so the new count begins cleanly.
  assign tick = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped countdown timer with sticky expired flag
// Purpose: LOAD/COUNT/CTRL-STATUS registers at BASE_ADDR..BASE_ADDR+2, IDLE/RUN/DONE FSM.
// Build option: define MMIO_TIMER_AUTORELOAD_EN to reload COUNT from LOAD on expiry and keep running.
// Ports: clk, reset (async active-low), mem_cmd/mem_addr/write_data (bus in),
//        read_data (comb register value), rd_hit (comb read decode), expired (registered sticky flag).
module mmio_timer
  import mmio_pkg::*;
#(
  parameter logic [8:0]  BASE_ADDR = 9'h180,
  parameter int unsigned PRESCALE  = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        rd_hit,
  output logic        expired
);

`ifdef MMIO_TIMER_AUTORELOAD_EN
  localparam logic AUTORELOAD = 1'b1;
`else
  localparam logic AUTORELOAD = 1'b0;
`endif

  timer_state_e state_q, state_d;
  logic [15:0]  load_q, count_q, count_d;
  logic         expired_q, expired_d;
  logic         tick, running;

  // Offset relative to the base; modulo-512 arithmetic keeps the decode correct near 9'h1FF.
  logic [8:0] off_full;
  logic [1:0] off;
  logic       in_range, wr_hit;
  logic       start_cmd, stop_cmd, clear_cmd;

  assign off_full = mem_addr - BASE_ADDR;
  assign in_range = (off_full < 9'd3);
  assign off      = off_full[1:0];
  assign rd_hit   = in_range && (mem_cmd == MREAD);
  assign wr_hit   = in_range && (mem_cmd == MWRITE);

  assign start_cmd = wr_hit && (off == OFF_CTRL) && write_data[CTRL_START];
  assign stop_cmd  = wr_hit && (off == OFF_CTRL) && write_data[CTRL_STOP];
  assign clear_cmd = wr_hit && (off == OFF_CTRL) && write_data[CTRL_CLEAR];

  assign running = (state_q == ST_RUN);
  assign expired = expired_q;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (running),
    .clear  (start_cmd || stop_cmd),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      load_q    <= 16'd0;
      count_q   <= 16'd0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      if (wr_hit && (off == OFF_LOAD)) begin
        load_q <= write_data;
      end
    end
  end

  // Priority stop > start > tick; the clear is applied first so an expiry at the same edge wins.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = expired_q;
    if (clear_cmd) begin
      expired_d = 1'b0;
    end
    if (stop_cmd) begin
      state_d = ST_IDLE;
    end else if (start_cmd) begin
      count_d = load_q;
      if (load_q == 16'd0) begin
        state_d   = ST_DONE;
        expired_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (running && tick) begin
      if (count_q <= 16'd1) begin
        expired_d = 1'b1;
        if (AUTORELOAD && (load_q != 16'd0)) begin
          count_d = load_q;
        end else begin
          count_d = 16'd0;
          state_d = ST_DONE;
        end
      end else begin
        count_d = count_q - 16'd1;
      end
    end
  end

  always_comb begin
    read_data = 16'h0000;
    if (rd_hit) begin
      case (off)
        OFF_LOAD:  read_data = load_q;
        OFF_COUNT: read_data = count_q;
        OFF_CTRL:  read_data = {13'b0, AUTORELOAD, expired_q, running};
        default:   read_data = 16'h0000;
      endcase
    end
  end

endmodule
